dp_fx_sequencer: RTL and testbench
==================================

// Module: dp_fx_sequencer
// PURPOSE
//  Parametrised datapath sequencer for the audio effects path. Per sample it
//  reads the main sample buffer, then each enabled effect tap (reverb, chorus,
//  ...) in ascending index order. It then raises a one-cycle transfer-ready
//  strobe and advances the shared buffer address. Finally it holds in the MCU
//  SPI phase until the transfer completes or times out.
// PARAMETERS
//  NUM_FX      2     number of effect taps (>=1); bit i of fx_en/fx_read = tap i
//  ADDR_W      12    width of rd_adr
//  DEPTH       4096  buffer depth; rd_adr wraps at DEPTH-1 (DEPTH <= 2**ADDR_W)
//  SPI_TMO     255   max cycles transmit may stay high in MCU_SPI (>=1)
// PORTS
//  clk          in   1        system clock; all logic on rising edge
//  reset        in   1        synchronous, active-low reset (0 = reset)
//  start        in   1        begin one sample sequence; sampled only in IDLE
//  transmit     in   1        MCU SPI transfer in progress
//  fx_en        in   NUM_FX   effect tap enables; latched when start is accepted
//  main_read    out  1        read strobe, main sample buffer
//  fx_read      out  NUM_FX   one-hot read strobe, current effect tap
//  tfr_ready    out  1        sample set ready for MCU transfer (1 cycle)
//  inc_adr      out  1        address advance strobe (same cycle as tfr_ready)
//  rd_adr       out  ADDR_W   current buffer read address
//  wrap         out  1        1-cycle pulse when rd_adr wraps DEPTH-1 -> 0
//  busy         out  1        state != IDLE
//  timeout_err  out  1        sticky: SPI transfer exceeded SPI_TMO
// BEHAVIOUR
//  - Reset (reset==0 at clk edge) overrides everything, including mid-sequence:
//    state=IDLE, rd_adr=0, fx latch=0, tap index=0, timeout count=0,
//    timeout_err=0; all strobes, wrap and busy = 0.
//  - States: IDLE, READ_MAIN, READ_FX, READY, MCU_SPI. Strobe outputs are
//    Moore decodes of registered state. wrap and timeout_err are registered.
//  - IDLE: start=1 -> READ_MAIN, latch fx_en, clear timeout_err. start is
//    ignored in every other state; a later fx_en change does not affect the
//    running sequence.
//  - READ_MAIN (1 cycle, main_read=1): any latched enable -> READ_FX at the
//    lowest enabled index. No enables -> READY.
//  - READ_FX: 1 cycle per enabled tap; fx_read = one-hot of the current index.
//    Disabled taps are skipped with zero cycles. After the highest enabled tap
//    -> READY.
//  - READY (1 cycle): tfr_ready=1, inc_adr=1. At the end of the cycle,
//    rd_adr <= (rd_adr==DEPTH-1) ? 0 : rd_adr+1. wrap=1 in the next cycle only
//    on the wrap. Next state is MCU_SPI.
//  - MCU_SPI: transmit=0 -> IDLE. transmit=1 -> stay, incrementing the timeout
//    count. When the count reaches SPI_TMO with transmit still 1: set
//    timeout_err, go to IDLE. The count clears on entry to MCU_SPI.
//  - Latency with E enabled taps: start accepted at edge k. main_read is high
//    in cycle k+1, fx reads in k+2..k+1+E, tfr_ready in k+2+E, MCU_SPI from
//    k+3+E. Minimum sequence is E+3 cycles before a new start is accepted.
//  - start held high continuously: a new sequence begins on the first IDLE
//    cycle (back-to-back operation).
//  - Widths: tap index is $clog2(NUM_FX) bits (min 1). Timeout counter is
//    $clog2(SPI_TMO+1) bits and saturates; it never wraps.
// TESTING
//  1 NUM_FX=3, fx_en=3'b101, pulse start -> main_read 1 cyc, fx_read 001 then
//    100 (tap1 skipped), tfr_ready+inc_adr 1 cyc, rd_adr 0->1, back in IDLE.
//  2 fx_en=0, start -> main_read, then tfr_ready the very next cycle;
//    fx_read never nonzero.
//  3 Preload rd_adr=DEPTH-1 (4095) by repeated sequences -> after READY
//    rd_adr=0 and wrap=1 for exactly one cycle.
//  4 transmit held high 300 cycles, SPI_TMO=255 -> timeout_err=1 after 255
//    cycles in MCU_SPI, state IDLE. Next start clears timeout_err.
//  5 reset=0 asserted during READ_FX -> next cycle all outputs 0, rd_adr=0;
//    start pulsed while busy (no reset) -> ignored, no extra sequence.
//  6 fx_en changed 3'b111->3'b000 mid-sequence -> all three taps still read
//    for the current sample; the new value is used on the next start.

Source files
------------

// File: rtl/dp_fx_sequencer.sv
// Audio effects datapath sequencer: main read, enabled taps in order,
// transfer-ready strobe with address advance, then MCU SPI wait with timeout.
module dp_fx_sequencer #(
  parameter int NUM_FX  = 2,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4096,
  parameter int SPI_TMO = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              transmit_i,
  input  logic [NUM_FX-1:0] fx_en_i,
  output logic              main_read_o,
  output logic [NUM_FX-1:0] fx_read_o,
  output logic              tfr_ready_o,
  output logic              inc_adr_o,
  output logic [ADDR_W-1:0] rd_adr_o,
  output logic              wrap_o,
  output logic              busy_o,
  output logic              timeout_err_o
);

  localparam int IDX_W = (NUM_FX > 1) ? $clog2(NUM_FX) : 1;
  localparam int CNT_W = $clog2(SPI_TMO + 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_MAIN,
    READ_FX,
    READY,
    MCU_SPI
  } state_t;

  state_t            state_q;
  logic [NUM_FX-1:0] fx_q;
  logic [NUM_FX-1:0] fx_d;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] adr_q;
  logic [ADDR_W-1:0] adr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              adr_max;
  logic              wrap_q;
  logic              err_q;

  function automatic logic [IDX_W-1:0] lowest(
    input logic [NUM_FX-1:0] m
  );
    lowest = '0;
    for (int i = NUM_FX - 1; i >= 0; i--)
      if (m[i]) lowest = IDX_W'(i);
  endfunction

  // fx_q holds taps still pending; each visited tap is retired
  assign fx_d    = fx_q & ~(NUM_FX'(1) << idx_q);
  assign adr_max = (adr_q == ADDR_W'(DEPTH - 1));
  assign adr_d   = adr_max ? '0 : adr_q + 1'b1;
  assign cnt_d   = (cnt_q == CNT_W'(SPI_TMO)) ? cnt_q
                                              : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      fx_q    <= '0;
      idx_q   <= '0;
      adr_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= READ_MAIN;
            fx_q    <= fx_en_i;
            err_q   <= 1'b0;
          end
        end
        READ_MAIN: begin
          if (|fx_q) begin
            state_q <= READ_FX;
            idx_q   <= lowest(fx_q);
          end else begin
            state_q <= READY;
          end
        end
        READ_FX: begin
          fx_q <= fx_d;
          if (|fx_d) idx_q <= lowest(fx_d);
          else       state_q <= READY;
        end
        READY: begin
          adr_q   <= adr_d;
          wrap_q  <= adr_max;
          cnt_q   <= '0;
          state_q <= MCU_SPI;
        end
        MCU_SPI: begin
          if (!transmit_i) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(SPI_TMO)) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign main_read_o   = (state_q == READ_MAIN);
  assign fx_read_o     = (state_q == READ_FX) ?
                         (NUM_FX'(1) << idx_q) : '0;
  assign tfr_ready_o   = (state_q == READY);
  assign inc_adr_o     = (state_q == READY);
  assign rd_adr_o      = adr_q;
  assign wrap_o        = wrap_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_dp_fx_sequencer.sv
// Directed bench for dp_fx_sequencer (NUM_FX=3): tap order, skip,
// address wrap, SPI timeout, reset and start/fx_en isolation.
module tb_dp_fx_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        transmit;
  logic [2:0]  fx_en;
  logic        main_read;
  logic [2:0]  fx_read;
  logic        tfr_ready;
  logic        inc_adr;
  logic [11:0] rd_adr;
  logic        wrap;
  logic        busy;
  logic        terr;

  int n_chk  = 0;
  int n_fail = 0;

  // {main, fx[2:0], tfr, inc, wrap, busy, err}
  localparam logic [8:0] O_IDLE = 9'b0_000_0_0_0_0_0;
  localparam logic [8:0] O_MAIN = 9'b1_000_0_0_0_1_0;
  localparam logic [8:0] O_FX0  = 9'b0_001_0_0_0_1_0;
  localparam logic [8:0] O_FX1  = 9'b0_010_0_0_0_1_0;
  localparam logic [8:0] O_FX2  = 9'b0_100_0_0_0_1_0;
  localparam logic [8:0] O_RDY  = 9'b0_000_1_1_0_1_0;
  localparam logic [8:0] O_SPI  = 9'b0_000_0_0_0_1_0;
  localparam logic [8:0] O_SPIW = 9'b0_000_0_0_1_1_0;
  localparam logic [8:0] O_ERR  = 9'b0_000_0_0_0_0_1;

  dp_fx_sequencer #(
    .NUM_FX (3),
    .ADDR_W (12),
    .DEPTH  (4096),
    .SPI_TMO(255)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .start_i      (start),
    .transmit_i   (transmit),
    .fx_en_i      (fx_en),
    .main_read_o  (main_read),
    .fx_read_o    (fx_read),
    .tfr_ready_o  (tfr_ready),
    .inc_adr_o    (inc_adr),
    .rd_adr_o     (rd_adr),
    .wrap_o       (wrap),
    .busy_o       (busy),
    .timeout_err_o(terr)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {main_read, fx_read, tfr_ready,
            inc_adr, wrap, busy, terr};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag,
                     input logic [8:0] exp);
    @(negedge clk);
    check(tag, 32'(outs()), 32'(exp));
  endtask

  task automatic go(input logic [2:0] en);
    start = 1'b1;
    fx_en = en;
    @(negedge clk);
    check("main", 32'(outs()), 32'(O_MAIN));
    start = 1'b0;
  endtask

  int n;

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    transmit = 1'b0;
    fx_en    = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("rst_outs", 32'(outs()), 32'(O_IDLE));
    check("rst_adr", 32'(rd_adr), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // tap 1 skipped
    go(3'b101);
    cyc("t1_fx0", O_FX0);
    cyc("t1_fx2", O_FX2);
    cyc("t1_rdy", O_RDY);
    check("t1_adr_rdy", 32'(rd_adr), 32'd0);
    cyc("t1_spi", O_SPI);
    check("t1_adr", 32'(rd_adr), 32'd1);
    cyc("t1_idle", O_IDLE);

    // no taps: ready right after main
    go(3'b000);
    cyc("t2_rdy", O_RDY);
    cyc("t2_spi", O_SPI);
    cyc("t2_idle", O_IDLE);
    check("t2_adr", 32'(rd_adr), 32'd2);

    // fx_en change mid-sequence is ignored
    go(3'b111);
    fx_en = 3'b000;
    cyc("t6_fx0", O_FX0);
    cyc("t6_fx1", O_FX1);
    cyc("t6_fx2", O_FX2);
    cyc("t6_rdy", O_RDY);
    cyc("t6_spi", O_SPI);
    cyc("t6_idle", O_IDLE);
    go(3'b000);
    cyc("t6_next_rdy", O_RDY);
    cyc("t6_next_spi", O_SPI);
    cyc("t6_next_idle", O_IDLE);
    check("t6_adr", 32'(rd_adr), 32'd4);

    // reset mid READ_FX
    go(3'b111);
    cyc("t5_fx0", O_FX0);
    reset_n = 1'b0;
    cyc("t5_rst", O_IDLE);
    check("t5_rst_adr", 32'(rd_adr), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    // start while busy is ignored
    go(3'b010);
    start = 1'b1;
    cyc("t5_fx1", O_FX1);
    start = 1'b0;
    cyc("t5_rdy", O_RDY);
    cyc("t5_spi", O_SPI);
    cyc("t5_idle", O_IDLE);
    cyc("t5_idle2", O_IDLE);
    check("t5_adr", 32'(rd_adr), 32'd1);

    // back-to-back up to DEPTH-1
    fx_en = 3'b000;
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 20000 && n < 4094; i++) begin
      @(negedge clk);
      if (wrap) check("t3_early_wrap", 32'd1, 32'd0);
      if (tfr_ready) n++;
    end
    start = 1'b0;
    check("t3_b2b_count", 32'(n), 32'd4094);
    cyc("t3_pre_spi", O_SPI);
    check("t3_adr_max", 32'(rd_adr), 32'd4095);
    cyc("t3_pre_idle", O_IDLE);
    go(3'b000);
    cyc("t3_rdy", O_RDY);
    cyc("t3_wrap", O_SPIW);
    check("t3_adr0", 32'(rd_adr), 32'd0);
    cyc("t3_wrap_gone", O_IDLE);

    // SPI timeout
    transmit = 1'b1;
    go(3'b000);
    cyc("t4_rdy", O_RDY);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("t4_spi_cycles", 32'(n), 32'd255);
    check("t4_err", 32'(outs()), 32'(O_ERR));
    cyc("t4_err_sticky", O_ERR);
    transmit = 1'b0;
    go(3'b000);
    cyc("t4_clr_rdy", O_RDY);
    // short transfer finishes cleanly
    transmit = 1'b1;
    repeat (5) cyc("t4_short_spi", O_SPI);
    transmit = 1'b0;
    cyc("t4_short_idle", O_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
